abs_diff_sad_pipe: RTL
======================

# abs_diff_sad_pipe

Parametrised, pipelined successor to the combinational 8-bit absolute-difference netlists. Computes |a − b| on a valid/ready stream at WIDTH bits, with an optional approximate mode that clears input LSBs. A sum-of-absolute-differences (SAD) mode accumulates blocks of up to ACC_LEN pairs. It sits between the stimulus source and the error-metric collectors, so exact and approximate difference units run under the same streaming harness.

## Interface
- WIDTH, 8: operand width in bits, ≥2.
- ACC_LEN, 16: maximum pairs per SAD block; power of two, ≥2.
- APPROX_LSB, 0: number of input LSBs forced to 0 before subtraction; 0 ≤ APPROX_LSB < WIDTH.
- OUT_W, derived = WIDTH + log2(ACC_LEN): result width.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  unsigned operand a.
- in_b  in  WIDTH  unsigned operand b.
- in_mode  in  1  0 = per-sample |a−b|, 1 = SAD; sampled only at block start.
- in_last  in  1  SAD mode: closes the block early; ignored in mode 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_W  |a−b| zero-extended (mode 0) or block SAD (mode 1).
- out_sign  out  1  mode 0: 1 if a_m < b_m; mode 1: 0.
- out_count  out  log2(ACC_LEN)+1  pairs summed into out_data (1 in mode 0).

## Operation
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All pipeline registers update only when adv is high. A transfer occurs when in_valid && in_ready.
- Input block tracker: blk_cnt (0..ACC_LEN−1) and blk_mode.
  - On a transfer with blk_cnt == 0, blk_mode takes in_mode. Otherwise blk_mode holds.
  - eff_mode = (blk_cnt == 0) ? in_mode : blk_mode.
  - eff_last = 1 when eff_mode == 0. Otherwise eff_last = in_last || blk_cnt == ACC_LEN−1.
  - blk_cnt returns to 0 on an eff_last transfer. It increments on any other transfer.
- S1 register: captures a_m and b_m, eff_mode and eff_last. a_m and b_m are in_a/in_b with the low APPROX_LSB bits cleared. s1_valid = transfer.
- S2 register: captures diff = |a_m − b_m| (WIDTH bits, no overflow), sign = (a_m < b_m), mode, last and valid from S1.
- Output stage, on adv with s2_valid:
  - Mode 0: out_data = diff, out_sign = sign, out_count = 1, out_valid = 1.
  - Mode 1, not last: acc += diff, acc_cnt += 1, out_valid = 0.
  - Mode 1, last: out_data = acc + diff, out_count = acc_cnt + 1, out_sign = 0, out_valid = 1. acc and acc_cnt then clear.
- On adv without s2_valid: out_valid = 0. acc is unchanged.
- The SAD result cannot overflow: ACC_LEN·(2^WIDTH−1) < 2^OUT_W.
- A mode change mid-block has no effect until the block closes. The next block then uses the newly sampled in_mode.
- A mode-0 beat following a closed SAD block is processed normally in the next cycle. The output stage never produces two results per cycle.

## Timing
- Reset values:
  - in_ready = 1; out_valid = 0; out_data = 0; out_sign = 0; out_count = 0.
  - s1_valid = s2_valid = 0; blk_cnt = 0; blk_mode = 0; acc = 0; acc_cnt = 0.
- Reset mid-block discards the partial SAD and any in-flight beats. No output is produced for them.
- Latency: a beat transferred on edge E produces its mode-0 result with out_valid high after edge E+2. A SAD result appears after edge E+2 of its last beat.
- Throughput: one beat per cycle while out_ready = 1. In mode 1, out_valid pulses once per block.
- Backpressure: with out_valid = 1 and out_ready = 0, adv = 0.
  - The whole pipeline freezes and in_ready = 0.
  - out_data, out_sign and out_count hold stable until the cycle after acceptance.
- in_ready depends combinationally on out_ready. There is no other combinational in→out path.

## Test plan
- Mode 0, WIDTH=8, APPROX_LSB=0: pairs (200,55), (55,200), (0,255), (7,7) -> out_data 145/145/255/0, out_sign 0/1/1/0, count 1, each two edges after acceptance.
- APPROX_LSB=2: (13,2) -> a_m=12, b_m=0, out_data 12; (3,1) -> 0, sign 0.
- Mode 1, ACC_LEN=16, 16 pairs (255,0) with no in_last -> single result: out_data 4080, out_count 16, out_sign 0; no other out_valid pulse.
- Mode 1 early close: (10,4), (4,10), (9,0) with in_last on the third beat, then a mode-0 beat (1,3) -> SAD 21 with count 3, next result 2 with sign 1; in_mode toggled during beat 2 is ignored.
- Backpressure: out_ready held low 5 cycles during a full-rate mode-0 stream -> in_ready low, output held stable, no beat lost or duplicated; order preserved on release.
- rst asserted after 5 beats of a SAD block, then a new 2-beat block (1,0), (2,0) with in_last -> out_data 3, count 2; nothing is emitted for the aborted block.

Source files
------------

// File: rtl/abs_diff_sad_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : abs_diff_sad_pipe
//  Purpose  : Pipelined |a-b| on a valid/ready stream with optional LSB
//             truncation (approximate mode) and a sum-of-absolute-differences
//             mode that accumulates blocks of up to ACC_LEN pairs.
//  Revision : 1.0 - initial release
// ============================================================================
module abs_diff_sad_pipe #(
    parameter  int WIDTH      = 8,
    parameter  int ACC_LEN    = 16,
    parameter  int APPROX_LSB = 0,
    localparam int CNT_W      = $clog2(ACC_LEN),
    localparam int OUT_W      = WIDTH + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sign,
    output logic [CNT_W:0]   out_count
);

    // Clears the APPROX_LSB low bits of each operand in approximate builds.
    localparam logic [WIDTH-1:0] c_lsb_mask = {WIDTH{1'b1}} << APPROX_LSB;
    localparam logic [CNT_W-1:0] c_blk_max  = CNT_W'(ACC_LEN - 1);

    logic             w_adv;
    logic             w_xfer;
    logic             w_eff_mode;
    logic             w_eff_last;
    logic [WIDTH-1:0] w_a_m;
    logic [WIDTH-1:0] w_b_m;
    logic             w_lt;
    logic [WIDTH-1:0] w_diff;

    logic [CNT_W-1:0] r_blk_cnt;
    logic             r_blk_mode;

    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_mode;
    logic             r_s1_last;
    logic             r_s1_valid;

    logic [WIDTH-1:0] r_s2_diff;
    logic             r_s2_sign;
    logic             r_s2_mode;
    logic             r_s2_last;
    logic             r_s2_valid;

    logic [OUT_W-1:0] r_acc;
    logic [CNT_W:0]   r_acc_cnt;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_sign;
    logic [CNT_W:0]   r_out_count;

    // Whole pipeline advances together; a stalled output freezes every stage.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_xfer   = in_valid && w_adv;

    // Mode is latched at block start so mid-block toggles are ignored.
    assign w_eff_mode = (r_blk_cnt == '0) ? in_mode : r_blk_mode;
    assign w_eff_last = w_eff_mode ? (in_last || (r_blk_cnt == c_blk_max)) : 1'b1;

    assign w_a_m = in_a & c_lsb_mask;
    assign w_b_m = in_b & c_lsb_mask;

    // Unsigned magnitude: subtract the smaller operand from the larger one.
    assign w_lt   = (r_s1_a < r_s1_b);
    assign w_diff = w_lt ? (r_s1_b - r_s1_a) : (r_s1_a - r_s1_b);

    // Block tracker: counts accepted beats within the current SAD block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_cnt  <= '0;
            r_blk_mode <= 1'b0;
        end else if (w_xfer) begin
            if (r_blk_cnt == '0) begin
                r_blk_mode <= in_mode;
            end
            if (w_eff_last) begin
                r_blk_cnt <= '0;
            end else begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    // Stage 1: register masked operands and block control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_a     <= w_a_m;
            r_s1_b     <= w_b_m;
            r_s1_mode  <= w_eff_mode;
            r_s1_last  <= w_eff_last;
            r_s1_valid <= w_xfer;
        end
    end

    // Stage 2: register the absolute difference and its sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_diff  <= '0;
            r_s2_sign  <= 1'b0;
            r_s2_mode  <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_adv) begin
            r_s2_diff  <= w_diff;
            r_s2_sign  <= w_lt;
            r_s2_mode  <= r_s1_mode;
            r_s2_last  <= r_s1_last;
            r_s2_valid <= r_s1_valid;
        end
    end

    // Output stage: emit per-sample results or accumulate and emit block SADs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_acc_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sign  <= 1'b0;
            r_out_count <= '0;
        end else if (w_adv) begin
            r_out_valid <= 1'b0;
            if (r_s2_valid) begin
                if (!r_s2_mode) begin
                    r_out_data  <= OUT_W'(r_s2_diff);
                    r_out_sign  <= r_s2_sign;
                    r_out_count <= (CNT_W+1)'(1);
                    r_out_valid <= 1'b1;
                end else if (!r_s2_last) begin
                    r_acc     <= r_acc + OUT_W'(r_s2_diff);
                    r_acc_cnt <= r_acc_cnt + 1'b1;
                end else begin
                    r_out_data  <= r_acc + OUT_W'(r_s2_diff);
                    r_out_count <= r_acc_cnt + 1'b1;
                    r_out_sign  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_acc_cnt   <= '0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sign  = r_out_sign;
    assign out_count = r_out_count;

endmodule
`default_nettype wire
